// File: rtl/debug_ctrl_if.sv
// Bus between the debug controller and its UART, instruction memory and CPU.
interface debug_ctrl_if #(
  parameter int unsigned DATA_LEN   = 8,
  parameter int unsigned SIZE       = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [DATA_LEN-1:0]   i_rx_data;
  logic                  i_rx_done;
  logic                  i_tx_full;
  logic                  o_tx_start;
  logic [DATA_LEN-1:0]   o_tx_data;
  logic                  o_imem_we;
  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [SIZE-1:0]       o_imem_data;
  logic [ADDR_WIDTH-1:0] i_pc;
  logic                  i_halt;
  logic                  o_cpu_en;

  // Controller side.
  modport slave (
    input  i_rx_data, i_rx_done, i_tx_full, i_pc, i_halt,
    output o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data, o_cpu_en
  );

  // Environment side (UART, memory, CPU).
  modport master (
    output i_rx_data, i_rx_done, i_tx_full, i_pc, i_halt,
    input  o_tx_start, o_tx_data, o_imem_we, o_imem_addr, o_imem_data, o_cpu_en
  );

endinterface

// File: rtl/debug_ctrl.sv
// debug_ctrl: loads a program from UART bytes into instruction memory, then runs or
// single-steps the CPU on byte commands and reports status bytes back over UART.
module debug_ctrl #(
  parameter int unsigned DATA_LEN        = 8,
  parameter int unsigned SIZE            = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_INSTRUCTION = 64
) (
  input logic         i_clk,
  input logic         i_rst_n,
  debug_ctrl_if.slave bus
);

  localparam int unsigned BytesPerWord = SIZE / DATA_LEN;
  localparam int unsigned ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam int unsigned IdxW         = $clog2(MAX_INSTRUCTION + 1);

  localparam logic [DATA_LEN-1:0] CmdLoad     = DATA_LEN'(8'h07);
  localparam logic [DATA_LEN-1:0] CmdRun      = DATA_LEN'(8'h08);
  localparam logic [DATA_LEN-1:0] CmdStepMode = DATA_LEN'(8'h09);
  localparam logic [DATA_LEN-1:0] CmdStep     = DATA_LEN'(8'h0A);
  localparam logic [DATA_LEN-1:0] StatHalt    = DATA_LEN'(8'hFF);

  typedef enum logic [2:0] {StLoad, StIdle, StRun, StStepWait, StStep, StDone} state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic [ByteCntW-1:0]      bcnt_q;
  logic [SIZE-DATA_LEN-1:0] asm_q;     // bytes received so far, newest at the top
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [SIZE-1:0]          data_q;
  logic                     cpu_en_q;
  logic                     cnt_req_q; // load finished; send the count a cycle after the write
  logic                     pend_vld_q;
  logic [DATA_LEN-1:0]      pend_data_q;

  logic [SIZE-1:0]          load_word;
  logic                     last_byte;
  logic                     last_idx;
  logic                     load_cmd;
  logic                     req_vld;
  logic [DATA_LEN-1:0]      req_data;
  logic                     unused_pc;

  assign unused_pc = ^bus.i_pc[ADDR_WIDTH-1:DATA_LEN];

  // Decode of the incoming byte against the load context.
  always_comb begin
    load_word = {bus.i_rx_data, asm_q};
    last_byte = (bcnt_q == ByteCntW'(BytesPerWord - 1));
    last_idx  = (idx_q == IdxW'(MAX_INSTRUCTION - 1));
    load_cmd  = bus.i_rx_done && (bus.i_rx_data == CmdLoad);
  end

  // Sequencer: loading, command decode, CPU enable and memory write strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StLoad;
      idx_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_en_q  <= 1'b0;
      cnt_req_q <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      cnt_req_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (bus.i_rx_done) begin
            asm_q <= {bus.i_rx_data, asm_q[SIZE-DATA_LEN-1:DATA_LEN]};
            if (last_byte) begin
              we_q   <= 1'b1;
              addr_q <= ADDR_WIDTH'(idx_q) << 2;
              data_q <= load_word;
              idx_q  <= idx_q + IdxW'(1);
              bcnt_q <= '0;
              if (load_word == '0 || last_idx) begin
                state_q   <= StIdle;
                cnt_req_q <= 1'b1;
              end
            end else begin
              bcnt_q <= bcnt_q + ByteCntW'(1);
            end
          end
        end
        StIdle: begin
          if (bus.i_rx_done) begin
            if (bus.i_rx_data == CmdRun) begin
              state_q  <= StRun;
              cpu_en_q <= 1'b1;
            end else if (bus.i_rx_data == CmdStepMode) begin
              state_q <= StStepWait;
            end else if (bus.i_rx_data == CmdLoad) begin
              state_q <= StLoad;
              idx_q   <= '0;
              bcnt_q  <= '0;
            end
          end
        end
        StRun: begin
          if (load_cmd) begin
            state_q  <= StLoad;
            cpu_en_q <= 1'b0;
            idx_q    <= '0;
            bcnt_q   <= '0;
          end else if (bus.i_halt) begin
            state_q  <= StDone;
            cpu_en_q <= 1'b0;
          end
        end
        StStepWait: begin
          if (bus.i_rx_done && bus.i_rx_data == CmdStep) begin
            state_q  <= StStep;
            cpu_en_q <= 1'b1;
          end else if (load_cmd) begin
            state_q <= StLoad;
            idx_q   <= '0;
            bcnt_q  <= '0;
          end
        end
        StStep: begin
          // First cycle is the enabled clock; second cycle reports the outcome.
          if (cpu_en_q) begin
            cpu_en_q <= 1'b0;
          end else begin
            state_q <= bus.i_halt ? StDone : StStepWait;
          end
        end
        StDone: begin
          if (load_cmd) begin
            state_q <= StLoad;
            idx_q   <= '0;
            bcnt_q  <= '0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // Status byte to queue this cycle, if any.
  always_comb begin
    req_vld  = 1'b0;
    req_data = '0;
    if (cnt_req_q) begin
      req_vld  = 1'b1;
      req_data = DATA_LEN'(idx_q);
    end else if (state_q == StRun && bus.i_halt && !load_cmd) begin
      req_vld  = 1'b1;
      req_data = StatHalt;
    end else if (state_q == StStep && !cpu_en_q) begin
      req_vld  = 1'b1;
      req_data = bus.i_halt ? StatHalt : bus.i_pc[DATA_LEN-1:0];
    end
  end

  // One-entry transmit holding register; a newer status byte replaces an unsent one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
    end else if (req_vld) begin
      pend_vld_q  <= 1'b1;
      pend_data_q <= req_data;
    end else if (bus.o_tx_start) begin
      pend_vld_q <= 1'b0;
    end
  end

  assign bus.o_tx_start  = pend_vld_q && !bus.i_tx_full;
  assign bus.o_tx_data   = pend_data_q;
  assign bus.o_imem_we   = we_q;
  assign bus.o_imem_addr = addr_q;
  assign bus.o_imem_data = data_q;
  assign bus.o_cpu_en    = cpu_en_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: randomized byte gaps, words, run lengths and PCs,
// checked against expectations computed from the load/run/step rules.
module tb_debug_ctrl;

  localparam int unsigned MaxInstr = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_ctrl_if #(.DATA_LEN(8), .SIZE(32), .ADDR_WIDTH(32)) bus ();

  debug_ctrl #(
    .DATA_LEN        (8),
    .SIZE            (32),
    .ADDR_WIDTH      (32),
    .MAX_INSTRUCTION (MaxInstr)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  int          en_cyc_q[$];
  int          bad_tx = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [31:0] prog_q[$];
  int          last_rx_cyc = 0;

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.o_imem_we) begin
        wr_addr_q.push_back(bus.o_imem_addr);
        wr_data_q.push_back(bus.o_imem_data);
        wr_cyc_q.push_back(cyc);
      end
      if (bus.o_tx_start) begin
        tx_q.push_back(bus.o_tx_data);
        tx_cyc_q.push_back(cyc);
        if (bus.i_tx_full || (prev_start && prev_data == bus.o_tx_data)) bad_tx++;
      end
      if (bus.o_cpu_en) en_cyc_q.push_back(cyc);
      prev_start = bus.o_tx_start;
      prev_data  = bus.o_tx_data;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    tx_q.delete(); tx_cyc_q.delete(); en_cyc_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // Drive one rx byte for one cycle, then leave `gap` idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    last_rx_cyc   = cyc;
    @(posedge clk); #1;
    bus.i_rx_done = 1'b0;
    idle(gap);
  endtask

  task automatic load_prog();
    logic [31:0] w;
    foreach (prog_q[i]) begin
      w = prog_q[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], $urandom_range(0, 2));
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w = $urandom;
    return (w == 32'h0) ? 32'h1 : w;
  endfunction

  // Words written: up to and including the first zero word, capped at memory depth.
  function automatic int model_nwords();
    int n = 0;
    foreach (prog_q[i]) begin
      n++;
      if (prog_q[i] == 32'h0 || n == MaxInstr) break;
    end
    return n;
  endfunction

  task automatic expect_load(input string tag, input bit chk_tx);
    int n = model_nwords();
    chk({tag, " wr count"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), wr_addr_q[i], 4 * i);
      chk($sformatf("%s wr%0d data", tag, i), wr_data_q[i], prog_q[i]);
    end
    if (wr_cyc_q.size() > 0) chk({tag, " wr latency"}, wr_cyc_q[$], last_rx_cyc + 1);
    if (chk_tx) begin
      chk({tag, " tx count"}, tx_q.size(), 1);
      if (tx_q.size() > 0 && wr_cyc_q.size() > 0) begin
        chk({tag, " tx byte"}, tx_q[0], n & 8'hFF);
        chk({tag, " tx cycle"}, tx_cyc_q[0], wr_cyc_q[$] + 1);
      end
    end
  endtask

  // Short random program ending in a zero word, from LOAD to IDLE.
  task automatic quick_load(input string tag, input int nz);
    prog_q.delete();
    for (int i = 0; i < nz; i++) prog_q.push_back(rnd_word());
    prog_q.push_back(32'h0);
    clear_mon();
    load_prog();
    idle(4);
    expect_load(tag, 1'b1);
  endtask

  // From IDLE: run, raise halt L cycles after the command.
  task automatic run_halt(input string tag, input int len);
    int n;
    clear_mon();
    send_byte(8'h08, 0);
    n = last_rx_cyc;
    wait_until(n + len);
    bus.i_halt = 1'b1;
    idle(1);
    bus.i_halt = 1'b0;
    idle(4);
    chk({tag, " en cycles"}, en_cyc_q.size(), len);
    if (en_cyc_q.size() > 0) begin
      chk({tag, " en first"}, en_cyc_q[0], n + 1);
      chk({tag, " en last"}, en_cyc_q[$], n + len);
    end
    chk({tag, " tx count"}, tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      chk({tag, " tx byte"}, tx_q[0], 8'hFF);
      chk({tag, " tx cycle"}, tx_cyc_q[0], n + len + 1);
    end
  endtask

  // From STEPWAIT: one step with the given PC and halt level.
  task automatic do_step(input string tag, input logic [7:0] pc, input logic halt);
    int n;
    clear_mon();
    bus.i_pc   = {24'h0, pc};
    bus.i_halt = halt;
    send_byte(8'h0A, 0);
    n = last_rx_cyc;
    idle(6);
    bus.i_halt = 1'b0;
    chk({tag, " en count"}, en_cyc_q.size(), 1);
    if (en_cyc_q.size() > 0) chk({tag, " en cycle"}, en_cyc_q[0], n + 1);
    chk({tag, " tx count"}, tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      chk({tag, " tx byte"}, tx_q[0], halt ? 8'hFF : pc);
      chk({tag, " tx cycle"}, tx_cyc_q[0], n + 3);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_we"}, bus.o_imem_we, 1'b0);
    chk({tag, " imem_addr"}, bus.o_imem_addr, 32'h0);
    chk({tag, " imem_data"}, bus.o_imem_data, 32'h0);
    chk({tag, " cpu_en"}, bus.o_cpu_en, 1'b0);
    chk({tag, " tx_start"}, bus.o_tx_start, 1'b0);
    chk({tag, " tx_data"}, bus.o_tx_data, 8'h00);
  endtask

  initial begin
    int rel_cyc;
    int n;
    logic [31:0] w;
    rst_n         = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_full = 1'b0;
    bus.i_pc      = 32'h0;
    bus.i_halt    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference MIPS program ending with the zero word.
    prog_q = '{32'h3C010003, 32'h3C020005, 32'h00221820, 32'h00221822, 32'h00412024,
               32'h00412825, 32'h0041302A, 32'hAC030004, 32'h8C040004, 32'h00642821,
               32'h00000000};
    clear_mon();
    load_prog();
    idle(4);
    expect_load("prog11", 1'b1);

    run_halt("run20", 20);

    // DONE ignores everything but load.
    clear_mon();
    send_byte(8'h08, 0);
    send_byte(8'h0A, 0);
    idle(4);
    chk("done ignores cmds en", en_cyc_q.size(), 0);
    chk("done ignores cmds tx", tx_q.size(), 0);

    send_byte(8'h07, 1);
    quick_load("reload", 3);

    // Step mode.
    send_byte(8'h09, 1);
    do_step("step04", 8'h04, 1'b0);
    do_step("step08", 8'h08, 1'b0);
    do_step("step0C", 8'h0C, 1'b0);
    clear_mon();
    send_byte(8'h08, 0);
    idle(4);
    chk("stepwait ignores run", en_cyc_q.size(), 0);
    for (int i = 0; i < 3; i++) do_step($sformatf("steprnd%0d", i), 8'($urandom), 1'b0);
    do_step("stephalt", 8'h44, 1'b1);
    clear_mon();
    send_byte(8'h0A, 0);
    idle(4);
    chk("done after step halt", en_cyc_q.size(), 0);

    // Full memory: 64 nonzero words, then the next bytes are commands.
    send_byte(8'h07, 1);
    prog_q.delete();
    for (int i = 0; i < MaxInstr; i++) prog_q.push_back(rnd_word());
    clear_mon();
    load_prog();
    idle(4);
    expect_load("max", 1'b1);
    if (wr_addr_q.size() > 0) chk("max last addr", wr_addr_q[$], 32'd252);
    clear_mon();
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h08, 1);
    send_byte(8'h33, 1);
    idle(2);
    chk("word65 no write", wr_addr_q.size(), 0);
    chk("word65 runs", en_cyc_q.size() > 0, 1'b1);
    bus.i_halt = 1'b1;
    idle(1);
    bus.i_halt = 1'b0;
    idle(3);
    chk("word65 halt tx", tx_q.size() > 0 ? tx_q[$] : 8'h00, 8'hFF);

    // Count byte held while the transmitter is full.
    clear_mon();
    bus.i_tx_full = 1'b1;
    send_byte(8'h07, 1);
    prog_q = '{rnd_word(), rnd_word(), 32'h0};
    load_prog();
    idle(6);
    chk("full wr count", wr_addr_q.size(), 3);
    chk("full held", tx_q.size(), 0);
    rel_cyc       = cyc;
    bus.i_tx_full = 1'b0;
    idle(6);
    chk("release tx count", tx_q.size(), 1);
    if (tx_q.size() > 0) begin
      chk("release tx byte", tx_q[0], 8'h03);
      chk("release tx cycle", tx_cyc_q[0], rel_cyc);
    end

    // Halt status replaces an unsent load count.
    bus.i_tx_full = 1'b1;
    send_byte(8'h07, 1);
    prog_q = '{rnd_word(), 32'h0};
    load_prog();
    idle(3);
    send_byte(8'h08, 0);
    n = last_rx_cyc;
    wait_until(n + 3);
    bus.i_halt = 1'b1;
    idle(1);
    bus.i_halt = 1'b0;
    idle(3);
    clear_mon();
    bus.i_tx_full = 1'b0;
    idle(5);
    chk("last wins count", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("last wins byte", tx_q[0], 8'hFF);

    // Reset after two bytes of a word.
    send_byte(8'h07, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("rst midword");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    w      = rnd_word();
    prog_q = '{w, 32'h0};
    clear_mon();
    load_prog();
    idle(4);
    expect_load("after rst", 1'b1);

    // Reset during RUN drops the enable without a clock edge.
    send_byte(8'h08, 4);
    chk("run before rst en", bus.o_cpu_en, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk("rst midrun en", bus.o_cpu_en, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Load command aborts RUN.
    quick_load("pre abort", 2);
    send_byte(8'h08, 3);
    clear_mon();
    send_byte(8'h07, 0);
    n = last_rx_cyc;
    idle(3);
    chk("abort en last", en_cyc_q.size() > 0 ? en_cyc_q[$] : -1, n);
    chk("abort no tx", tx_q.size(), 0);
    quick_load("post abort", 1);

    // A few random run lengths.
    for (int i = 0; i < 3; i++) begin
      run_halt($sformatf("runrnd%0d", i), $urandom_range(1, 30));
      send_byte(8'h07, 1);
      quick_load($sformatf("rl%0d", i), $urandom_range(1, 5));
    end

    chk("tx protocol", bad_tx, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
